wall_collide: RTL

Frame-rate collision checker on the consuming end of the wall geometry interface. Once per frame it latches a moving object's proposed next position and the four wall origins published by the wall generator. It then tests the object's square bounding box against each wall, one wall per clock. The block reports a per-wall hit mask and a single Blocked flag, which the motion logic uses to accept or reject the move.

---
 rtl/wall_pkg.sv | 41 ++++
 rtl/wall_overlap_check.sv | 21 ++
 rtl/wall_collide.sv | 125 ++++++++++++
 3 files changed

// File: rtl/wall_pkg.sv
// Shared constants, types and helpers for the wall collision checker.
package wall_pkg;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned EXT_W     = 11;
    localparam int unsigned NUM_WALLS = 4;
    localparam int unsigned IDX_W     = 2;

    localparam int unsigned OBJ_SIZE     = 16;
    localparam int unsigned SCREEN_X_MAX = 639;
    localparam int unsigned SCREEN_Y_MAX = 479;

    localparam int unsigned WALL_H_W = 64;
    localparam int unsigned WALL_H_H = 32;
    localparam int unsigned WALL_V_W = 32;
    localparam int unsigned WALL_V_H = 64;

    // Bit i set when wall i+1 is horizontal (walls 1 and 3).
    localparam logic [NUM_WALLS-1:0] WALL_IS_HORIZ = 4'b0101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

    function automatic logic [EXT_W-1:0] dim_w(input logic [IDX_W-1:0] idx);
        return WALL_IS_HORIZ[idx] ? EXT_W'(WALL_H_W) : EXT_W'(WALL_V_W);
    endfunction

    function automatic logic [EXT_W-1:0] dim_h(input logic [IDX_W-1:0] idx);
        return WALL_IS_HORIZ[idx] ? EXT_W'(WALL_H_H) : EXT_W'(WALL_V_H);
    endfunction

endpackage

// File: rtl/wall_overlap_check.sv
// Combinational box-versus-wall overlap test; wall extents are inclusive.
module wall_overlap_check
    import wall_pkg::*;
(
    input  logic [EXT_W-1:0] obj_x,
    input  logic [EXT_W-1:0] obj_y,
    input  logic [EXT_W-1:0] wall_x,
    input  logic [EXT_W-1:0] wall_y,
    input  logic [EXT_W-1:0] wall_w,
    input  logic [EXT_W-1:0] wall_h,
    output logic             hit_c
);

    localparam logic [EXT_W-1:0] OBJ_SPAN = EXT_W'(OBJ_SIZE - 1);

    assign hit_c = (obj_x <= wall_x + wall_w)
                && (obj_x + OBJ_SPAN >= wall_x)
                && (obj_y <= wall_y + wall_h)
                && (obj_y + OBJ_SPAN >= wall_y);

endmodule

// File: rtl/wall_collide.sv
// Frame-rate collision checker: one wall per clock through a shared comparator.
// Optional screen-edge blocking is enabled by defining WALL_COLLIDE_SCREEN_EDGE_EN.
module wall_collide
    import wall_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_clk,
    input  logic [COORD_W-1:0] Next_X,
    input  logic [COORD_W-1:0] Next_Y,
    input  logic [COORD_W-1:0] X1,
    input  logic [COORD_W-1:0] Y1,
    input  logic [COORD_W-1:0] X2,
    input  logic [COORD_W-1:0] Y2,
    input  logic [COORD_W-1:0] X3,
    input  logic [COORD_W-1:0] Y3,
    input  logic [COORD_W-1:0] X4,
    input  logic [COORD_W-1:0] Y4,
    output logic [NUM_WALLS-1:0] Hit_mask,
    output logic               Blocked,
    output logic               Valid,
    output logic               Busy
);

    state_t               state, state_next;
    logic                 sync1, sync2, dly;
    logic                 rise_c;
    point_t               obj_q;
    point_t               wall_q [NUM_WALLS];
    point_t               wall_in [NUM_WALLS];
    logic [IDX_W-1:0]     idx;
    logic [NUM_WALLS-1:0] acc;
    logic                 hit_c;
    logic                 blocked_c;

    assign wall_in[0] = '{x: X1, y: Y1};
    assign wall_in[1] = '{x: X2, y: Y2};
    assign wall_in[2] = '{x: X3, y: Y3};
    assign wall_in[3] = '{x: X4, y: Y4};

    assign rise_c = sync2 & ~dly;

    // Frame strobe synchronizer plus delay flop for rise detection.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dly   <= 1'b0;
        end else begin
            sync1 <= frame_clk;
            sync2 <= sync1;
            dly   <= sync2;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (rise_c) state_next = ST_LATCH;
            ST_LATCH: state_next = ST_CHECK;
            ST_CHECK: if (idx == IDX_W'(NUM_WALLS - 1)) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    wall_overlap_check u_check (
        .obj_x  (EXT_W'(obj_q.x)),
        .obj_y  (EXT_W'(obj_q.y)),
        .wall_x (EXT_W'(wall_q[idx].x)),
        .wall_y (EXT_W'(wall_q[idx].y)),
        .wall_w (dim_w(idx)),
        .wall_h (dim_h(idx)),
        .hit_c  (hit_c)
    );

`ifdef WALL_COLLIDE_SCREEN_EDGE_EN
    logic edge_c;
    assign edge_c = (EXT_W'(obj_q.x) + EXT_W'(OBJ_SIZE - 1) > EXT_W'(SCREEN_X_MAX))
                 || (EXT_W'(obj_q.y) + EXT_W'(OBJ_SIZE - 1) > EXT_W'(SCREEN_Y_MAX));
    assign blocked_c = (|acc) | edge_c;
`else
    assign blocked_c = |acc;
`endif

    // Datapath and registered outputs; Valid/Busy follow the next state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            obj_q    <= '0;
            for (int i = 0; i < NUM_WALLS; i++) wall_q[i] <= '0;
            idx      <= '0;
            acc      <= '0;
            Hit_mask <= '0;
            Blocked  <= 1'b0;
            Valid    <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            Valid <= (state_next == ST_DONE);
            Busy  <= (state_next != ST_IDLE);
            case (state)
                ST_LATCH: begin
                    obj_q <= '{x: Next_X, y: Next_Y};
                    for (int i = 0; i < NUM_WALLS; i++) wall_q[i] <= wall_in[i];
                    idx   <= '0;
                    acc   <= '0;
                end
                ST_CHECK: begin
                    acc <= acc | (NUM_WALLS'(hit_c) << idx);
                    idx <= idx + IDX_W'(1);
                end
                ST_DONE: begin
                    Hit_mask <= acc;
                    Blocked  <= blocked_c;
                end
                default: ;
            endcase
        end
    end

endmodule
